simd_muland_ctrl: RTL and testbench
===================================

Name: simd_muland_ctrl

Overview:
- Job scheduler and flow-control wrapper for one instance of the 9-stage pipelined simd_muland datapath.
- Accepts (x, y, mode, width) jobs over a valid/ready interface and issues at most one job per cycle.
- Holds the datapath's static mode/width configuration constant while any job is in flight. On a config change it drains the pipeline before reconfiguring.
- Collects results into an output FIFO with credit-based admission, so the datapath never needs backpressure.

Parameters:
- LAT, 9, datapath latency in cycles from dp_x_o/dp_y_o to dp_ps_i/dp_sc_i.
- FIFO_DEPTH, 16, output FIFO entries; power of two, must be >= LAT+1.
- SWITCH_CYC, 2, idle cycles inserted after a drain before new config is used.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- in_valid_i  in  1  job valid
- in_ready_o  out  1  job accepted when high with in_valid_i
- in_x_i  in  prng_t  operand x
- in_y_i  in  prng_t  operand y
- in_mode_i  in  3  mode, one-hot: 100, 010, 001
- in_width_i  in  3  lane width: 000=32, 001=64, 011=128, 111=256
- dp_x_o, dp_y_o  out  prng_t  datapath operands (registered)
- dp_mode_o  out  3  datapath mode (registered, static during RUN)
- dp_width_o  out  3  datapath width (registered, static during RUN)
- dp_ps_i, dp_sc_i  in  prng_t  datapath results
- out_valid_o  out  1  result valid
- out_ready_i  in  1  result consumed
- out_ps_o, out_sc_o  out  prng_t  result
- out_err_o  out  1  job had illegal mode/width; ps/sc forced to 0
- busy_o  out  1  jobs in flight or FIFO non-empty
- state_o  out  2  FSM state

Behaviour:
- Reset (async, rst_n_i=0):
  - FSM goes to IDLE; in_ready_o=0, out_valid_o=0, busy_o=0, out_err_o=0.
  - All dp_* outputs go to 0 and all tags are cleared.
  - FIFO pointers, credit count, and in-flight count go to 0.
- Reset mid-operation discards all in-flight jobs and FIFO contents; no result is emitted for them.
- FSM states (state_o encoding): IDLE=0, RUN=1, DRAIN=2, SWITCH=3.
  - IDLE: in_ready_o=0. When in_valid_i=1, latch in_mode_i/in_width_i into dp_mode_o/dp_width_o, then go to SWITCH.
  - SWITCH: in_ready_o=0; hold for SWITCH_CYC cycles, then go to RUN.
  - RUN: in_ready_o = (credits>0) and (in_valid_i=0 or the incoming config equals the current config).
    - A valid job with a different config deasserts in_ready_o and moves the FSM to DRAIN.
    - If in_valid_i=0 and busy_o=0, go to IDLE.
  - DRAIN: in_ready_o=0 until the in-flight count reaches 0 (FIFO may stay non-empty). Then latch the new config and go to SWITCH.
- Issue: on an accept edge, dp_x_o/dp_y_o load in_x_i/in_y_i. On non-accept cycles they load 0.
- A LAT-deep valid/err tag shift register tracks in-flight jobs; the result is captured into the FIFO when the tag exits.
- Latency: accept at edge t gives out_valid_o=1 after edge t+LAT+2 (FIFO empty, out_ready_i=1). Sustained throughput is 1 job/cycle.
- Credits:
  - Credits start at FIFO_DEPTH.
  - Decrement by 1 on accept; increment by 1 on an out_valid_o & out_ready_i pop.
  - A simultaneous accept and pop leaves credits unchanged.
  - Credits never exceed FIFO_DEPTH and never underflow.
  - This guarantees a FIFO write never meets a full FIFO.
- Illegal config (mode not one-hot, or width not in {000,001,011,111}):
  - The job is accepted and no config switch is triggered.
  - It is issued with x=y=0, and its tag has err=1.
  - The output carries out_err_o=1, ps=sc=0.
- Output is first-word fall-through. out_ps_o, out_sc_o, out_err_o stay stable while out_valid_o=1 and out_ready_i=0.
- Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: SIMD_MULAND_CTRL_STATS_EN.
- When defined, add outputs:
  - stat_jobs_o (32-bit accepted-job count)
  - stat_drain_cyc_o (32-bit cycles spent in DRAIN+SWITCH)
  - stat_err_o (16-bit illegal-job count)
- All counters saturate, reset to 0, and are cleared by the added input stat_clr_i (sync, 1 cycle).
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- TYPES (shared package):
  - ctrl_state_t enum (IDLE/RUN/DRAIN/SWITCH)
  - muland_cfg_t struct {mode[2:0], width[2:0]}
  - legal-width constants
  - function cfg_legal()
- Uses existing prng_t.
- Sub-module sync_fifo_fwft: parameterized width/depth, first-word fall-through, with full/empty flags.

Test Plan:
- Reset, then 20 back-to-back jobs with cfg {100,000}, out_ready_i=1 → first out_valid_o at accept+11 cycles, then 20 consecutive results matching the golden model, in order.
- out_ready_i=0, in_valid_i held for 40 cycles (FIFO_DEPTH=16) → exactly 16 accepts, in_ready_o=0 afterwards. Release out_ready_i → all 16 results emitted, no loss.
- 5 jobs {100,001} then job {010,111} → DRAIN until in-flight=0, then SWITCH for 2 cycles. dp_width_o changes only after the 5th result is captured; the 6th result is correct.
- Job with width 3'b010 → accepted, out_err_o=1, out_ps_o=out_sc_o=0, FSM stays in RUN.
- Assert rst_n_i=0 mid-stream with 7 jobs in flight → out_valid_o=0 immediately and no stale results after reset release.
- With SIMD_MULAND_CTRL_STATS_EN: 10 jobs including 1 config switch → stat_jobs_o=10 and stat_drain_cyc_o equals the measured DRAIN+SWITCH cycles; stat_clr_i → all counters 0.

Source files
------------

// File: rtl/simd_muland_ctrl_pkg.sv
// Shared types for the simd_muland job controller: FSM states, datapath config,
// result record and the config legality check.
package simd_muland_ctrl_pkg;

  typedef logic [63:0] prng_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    SWITCH = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic [2:0] mode;
    logic [2:0] width;
  } muland_cfg_t;

  typedef struct packed {
    logic  err;
    prng_t ps;
    prng_t sc;
  } res_t;

  localparam logic [2:0] WIDTH_32  = 3'b000;
  localparam logic [2:0] WIDTH_64  = 3'b001;
  localparam logic [2:0] WIDTH_128 = 3'b011;
  localparam logic [2:0] WIDTH_256 = 3'b111;

  function automatic logic cfg_legal(input muland_cfg_t cfg);
    logic mode_ok;
    logic width_ok;
    mode_ok  = cfg.mode inside {3'b100, 3'b010, 3'b001};
    width_ok = cfg.width inside {WIDTH_32, WIDTH_64, WIDTH_128, WIDTH_256};
    return mode_ok && width_ok;
  endfunction

endpackage

// File: rtl/simd_muland_ctrl_fifo.sv
// sync_fifo_fwft: single-clock first-word fall-through FIFO with full/empty flags.
// Head entry is presented on rd_data whenever empty is low.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Extra pointer MSB distinguishes full from empty when the indices coincide.
  assign rd_data = mem[rd_ptr_q[AW-1:0]];
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/simd_muland_ctrl.sv
// simd_muland_ctrl: job scheduler and result collector around the pipelined simd_muland datapath.
// Define SIMD_MULAND_CTRL_STATS_EN to add saturating job/drain/error counters.
module simd_muland_ctrl
  import simd_muland_ctrl_pkg::*;
#(
  parameter int LAT        = 9,
  parameter int FIFO_DEPTH = 16,
  parameter int SWITCH_CYC = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  prng_t       in_x_i,
  input  prng_t       in_y_i,
  input  logic [2:0]  in_mode_i,
  input  logic [2:0]  in_width_i,
  output prng_t       dp_x_o,
  output prng_t       dp_y_o,
  output logic [2:0]  dp_mode_o,
  output logic [2:0]  dp_width_o,
  input  prng_t       dp_ps_i,
  input  prng_t       dp_sc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output prng_t       out_ps_o,
  output prng_t       out_sc_o,
  output logic        out_err_o,
  output logic        busy_o,
  output logic [1:0]  state_o
`ifdef SIMD_MULAND_CTRL_STATS_EN
  ,
  input  logic        stat_clr_i,
  output logic [31:0] stat_jobs_o,
  output logic [31:0] stat_drain_cyc_o,
  output logic [15:0] stat_err_o
`endif
);

  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int SCW = (SWITCH_CYC > 1) ? $clog2(SWITCH_CYC + 1) : 1;

  ctrl_state_t     state_q, state_d;
  muland_cfg_t     cfg_q;
  muland_cfg_t     in_cfg;
  logic            in_legal;
  logic            cfg_match;
  logic            cfg_load;
  logic            accept;
  logic            pop;
  logic            busy;
  logic [SCW-1:0]  sw_cnt_q;
  logic [CW-1:0]   credits_q;
  logic [CW-1:0]   inflight_q;
  logic [LAT-1:0]  tag_v_q;
  logic [LAT-1:0]  tag_e_q;
  logic            cap_v_q;
  logic            cap_e_q;
  logic            res_v_q;
  res_t            res_q;
  res_t            fifo_rd;
  logic            fifo_full;
  logic            fifo_empty;

  assign in_cfg    = '{mode: in_mode_i, width: in_width_i};
  assign in_legal  = cfg_legal(in_cfg);
  assign cfg_match = (in_cfg == cfg_q);
  assign accept    = in_valid_i && in_ready_o;
  assign pop       = out_valid_o && out_ready_i;
  assign busy      = (inflight_q != '0) || !fifo_empty;

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    in_ready_o = 1'b0;
    cfg_load   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          cfg_load = 1'b1;
          state_d  = SWITCH;
        end
      end
      SWITCH: begin
        if (sw_cnt_q == SCW'(SWITCH_CYC - 1)) state_d = RUN;
      end
      RUN: begin
        // Illegal jobs ride through with the current config and never force a switch.
        if (in_valid_i) begin
          if (!in_legal || cfg_match) in_ready_o = (credits_q != '0);
          else                        state_d    = DRAIN;
        end else begin
          in_ready_o = (credits_q != '0);
          if (!busy) state_d = IDLE;
        end
      end
      DRAIN: begin
        if (inflight_q == '0) begin
          cfg_load = in_valid_i && in_legal;
          state_d  = SWITCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      sw_cnt_q <= '0;
      cfg_q    <= '0;
      dp_x_o   <= '0;
      dp_y_o   <= '0;
    end else begin
      state_q  <= state_d;
      sw_cnt_q <= (state_q == SWITCH) ? sw_cnt_q + SCW'(1) : '0;
      if (cfg_load) cfg_q <= in_cfg;
      dp_x_o   <= (accept && in_legal) ? in_x_i : '0;
      dp_y_o   <= (accept && in_legal) ? in_y_i : '0;
    end
  end

  assign dp_mode_o  = cfg_q.mode;
  assign dp_width_o = cfg_q.width;

  // Tags line up with dp_*_i one cycle after leaving the shift register; results are
  // then registered once more before entering the FIFO.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tag_v_q <= '0;
      tag_e_q <= '0;
      cap_v_q <= 1'b0;
      cap_e_q <= 1'b0;
      res_v_q <= 1'b0;
      res_q   <= '0;
    end else begin
      tag_v_q <= {tag_v_q[LAT-2:0], accept};
      tag_e_q <= {tag_e_q[LAT-2:0], accept && !in_legal};
      cap_v_q <= tag_v_q[LAT-1];
      cap_e_q <= tag_e_q[LAT-1];
      res_v_q <= cap_v_q;
      res_q   <= '{err: cap_e_q,
                   ps:  cap_e_q ? '0 : dp_ps_i,
                   sc:  cap_e_q ? '0 : dp_sc_i};
    end
  end

  // Credits count free FIFO slots not yet promised to an in-flight job.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      credits_q  <= CW'(FIFO_DEPTH);
      inflight_q <= '0;
    end else begin
      unique case ({accept, pop})
        2'b10:   credits_q <= credits_q - CW'(1);
        2'b01:   credits_q <= credits_q + CW'(1);
        default: ;
      endcase
      unique case ({accept, res_v_q})
        2'b10:   inflight_q <= inflight_q + CW'(1);
        2'b01:   inflight_q <= inflight_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_n_i) assert (!(res_v_q && fifo_full));
  end

  sync_fifo_fwft #(
    .WIDTH ($bits(res_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .wr_en   (res_v_q),
    .wr_data (res_q),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid_o = !fifo_empty;
  assign out_ps_o    = fifo_empty ? '0 : fifo_rd.ps;
  assign out_sc_o    = fifo_empty ? '0 : fifo_rd.sc;
  assign out_err_o   = !fifo_empty && fifo_rd.err;
  assign busy_o      = busy;
  assign state_o     = state_q;

`ifdef SIMD_MULAND_CTRL_STATS_EN
  logic [31:0] stat_jobs_q;
  logic [31:0] stat_drain_q;
  logic [15:0] stat_err_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stat_jobs_q  <= '0;
      stat_drain_q <= '0;
      stat_err_q   <= '0;
    end else if (stat_clr_i) begin
      stat_jobs_q  <= '0;
      stat_drain_q <= '0;
      stat_err_q   <= '0;
    end else begin
      if (accept && stat_jobs_q != '1) stat_jobs_q <= stat_jobs_q + 32'd1;
      if ((state_q == DRAIN || state_q == SWITCH) && stat_drain_q != '1)
        stat_drain_q <= stat_drain_q + 32'd1;
      if (accept && !in_legal && stat_err_q != '1) stat_err_q <= stat_err_q + 16'd1;
    end
  end

  assign stat_jobs_o      = stat_jobs_q;
  assign stat_drain_cyc_o = stat_drain_q;
  assign stat_err_o       = stat_err_q;
`endif

endmodule

// File: tb/tb_simd_muland_ctrl.sv
// Directed bench for simd_muland_ctrl with a LAT-stage datapath stand-in and an
// in-order scoreboard of expected results.
module tb_simd_muland_ctrl;
  import simd_muland_ctrl_pkg::*;

  localparam int LAT = 9;

  logic       clk = 1'b0;
  logic       rst_n_i;
  logic       in_valid_i;
  logic       in_ready_o;
  prng_t      in_x_i, in_y_i;
  logic [2:0] in_mode_i, in_width_i;
  prng_t      dp_x_o, dp_y_o;
  logic [2:0] dp_mode_o, dp_width_o;
  prng_t      dp_ps_i, dp_sc_i;
  logic       out_valid_o;
  logic       out_ready_i;
  prng_t      out_ps_o, out_sc_o;
  logic       out_err_o;
  logic       busy_o;
  logic [1:0] state_o;
`ifdef SIMD_MULAND_CTRL_STATS_EN
  logic        stat_clr_i;
  logic [31:0] stat_jobs_o, stat_drain_cyc_o;
  logic [15:0] stat_err_o;
`endif

  simd_muland_ctrl #(.LAT(LAT), .FIFO_DEPTH(16), .SWITCH_CYC(2)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_x_i      (in_x_i),
    .in_y_i      (in_y_i),
    .in_mode_i   (in_mode_i),
    .in_width_i  (in_width_i),
    .dp_x_o      (dp_x_o),
    .dp_y_o      (dp_y_o),
    .dp_mode_o   (dp_mode_o),
    .dp_width_o  (dp_width_o),
    .dp_ps_i     (dp_ps_i),
    .dp_sc_i     (dp_sc_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_ps_o    (out_ps_o),
    .out_sc_o    (out_sc_o),
    .out_err_o   (out_err_o),
    .busy_o      (busy_o),
    .state_o     (state_o)
`ifdef SIMD_MULAND_CTRL_STATS_EN
    ,
    .stat_clr_i       (stat_clr_i),
    .stat_jobs_o      (stat_jobs_o),
    .stat_drain_cyc_o (stat_drain_cyc_o),
    .stat_err_o       (stat_err_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stand-in: LAT registers from dp_x_o/dp_y_o to dp_ps_i/dp_sc_i.
  function automatic prng_t f_ps(prng_t x, prng_t y, logic [2:0] m);
    return (x * y) ^ {61'd0, m};
  endfunction
  function automatic prng_t f_sc(prng_t x, prng_t y, logic [2:0] w);
    return (x ^ ~y) + {61'd0, w};
  endfunction
  function automatic logic legal(logic [2:0] m, logic [2:0] w);
    logic mo, wo;
    mo = (m == 3'b100) || (m == 3'b010) || (m == 3'b001);
    wo = (w == 3'b000) || (w == 3'b001) || (w == 3'b011) || (w == 3'b111);
    return mo && wo;
  endfunction

  prng_t ps_pipe [LAT];
  prng_t sc_pipe [LAT];
  always @(posedge clk) begin
    ps_pipe[0] <= f_ps(dp_x_o, dp_y_o, dp_mode_o);
    sc_pipe[0] <= f_sc(dp_x_o, dp_y_o, dp_width_o);
    for (int k = 1; k < LAT; k++) begin
      ps_pipe[k] <= ps_pipe[k-1];
      sc_pipe[k] <= sc_pipe[k-1];
    end
  end
  assign dp_ps_i = ps_pipe[LAT-1];
  assign dp_sc_i = sc_pipe[LAT-1];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  typedef struct { prng_t ps; prng_t sc; logic err; } exp_t;
  exp_t sbq[$];

  int         n_pop = 0, n_err_out = 0, first_vld = -1, last_pop = -1;
  int         n_drain = 0, n_switch = 0, chg_pops = -1;
  logic       chg_armed = 1'b0;
  logic [2:0] prev_width = 3'b000;

  // Monitor: everything sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (rst_n_i) begin
      if (state_o == 2'd2) n_drain++;
      if (state_o == 2'd3) n_switch++;
      if (out_valid_o && first_vld < 0) first_vld = cyc;
      if (in_valid_i && in_ready_o) begin
        if (legal(in_mode_i, in_width_i))
          sbq.push_back('{f_ps(in_x_i, in_y_i, in_mode_i), f_sc(in_x_i, in_y_i, in_width_i), 1'b0});
        else
          sbq.push_back('{64'd0, 64'd0, 1'b1});
      end
      if (out_valid_o && out_ready_i) begin
        if (sbq.size() == 0) check("unexpected_out", {63'd0, out_valid_o}, 64'd0);
        else begin
          exp_t e;
          e = sbq.pop_front();
          check("out_ps", out_ps_o, e.ps);
          check("out_sc", out_sc_o, e.sc);
          check("out_err", {63'd0, out_err_o}, {63'd0, e.err});
        end
        if (out_err_o) n_err_out++;
        n_pop++;
        last_pop = cyc;
      end
      if (chg_armed && dp_width_o != prev_width) begin
        chg_pops  = n_pop;
        chg_armed = 1'b0;
      end
      prev_width = dp_width_o;
    end
  end

  task automatic send(input prng_t x, input prng_t y, input logic [2:0] m,
                      input logic [2:0] w, output int acc_cyc);
    in_x_i = x; in_y_i = y; in_mode_i = m; in_width_i = w; in_valid_i = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (in_ready_o) begin
        @(posedge clk); #1;
        acc_cyc = cyc;
        break;
      end
    end
    if (acc_cyc < 0) check("accept_timeout", {63'd0, in_ready_o}, 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    in_valid_i = 1'b0;
    while (!(state_o == 2'd0 && !busy_o) && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 500) check("idle_timeout", {63'd0, busy_o}, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc0, acc, base, accepts;
    rst_n_i = 1'b0; in_valid_i = 1'b0; in_x_i = '0; in_y_i = '0;
    in_mode_i = 3'b000; in_width_i = 3'b000; out_ready_i = 1'b1;
`ifdef SIMD_MULAND_CTRL_STATS_EN
    stat_clr_i = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {63'd0, in_ready_o}, 64'd0);
    check("rst_valid", {63'd0, out_valid_o}, 64'd0);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_err", {63'd0, out_err_o}, 64'd0);
    check("rst_state", {62'd0, state_o}, 64'd0);
    check("rst_dp_x", dp_x_o, 64'd0);
    check("rst_dp_cfg", {58'd0, dp_mode_o, dp_width_o}, 64'd0);
    rst_n_i = 1'b1;
    @(posedge clk); #1;

    // 20 back-to-back jobs, cfg {100,000}
    base = n_pop; first_vld = -1;
    send(64'h1, 64'h3, 3'b100, 3'b000, acc0);
    for (int i = 1; i < 20; i++)
      send(64'h1000 + 64'(i) * 64'h1111, 64'h77 + 64'(i), 3'b100, 3'b000, acc);
    wait_idle();
    check("first_latency", 64'(first_vld - acc0), 64'd11);
    check("t1_count", 64'(n_pop - base), 64'd20);
    check("t1_back_to_back", 64'(last_pop - first_vld), 64'd19);
    check("t1_idle_state", {62'd0, state_o}, 64'd0);

    // Credit exhaustion with the output stalled
    base = n_pop; accepts = 0; out_ready_i = 1'b0;
    in_mode_i = 3'b010; in_width_i = 3'b011; in_x_i = 64'hA0; in_y_i = 64'h5; in_valid_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (in_ready_o) accepts++;
      @(posedge clk); #1;
      in_x_i = 64'hA0 + 64'(accepts);
      in_y_i = 64'h5 + 64'(accepts) * 64'h3;
    end
    @(negedge clk); #1;
    check("credit_accepts", 64'(accepts), 64'd16);
    check("credit_ready_low", {63'd0, in_ready_o}, 64'd0);
    check("credit_no_pop", 64'(n_pop - base), 64'd0);
    @(posedge clk); #1;
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    wait_idle();
    check("credit_drained", 64'(n_pop - base), 64'd16);

    // Config switch: 5 jobs {100,001} then {010,111}
    base = n_pop;
    for (int i = 0; i < 5; i++)
      send(64'hBEEF + 64'(i), 64'h10 + 64'(i), 3'b100, 3'b001, acc);
    n_drain = 0; n_switch = 0; chg_pops = -1; chg_armed = 1'b1;
    send(64'hCAFE, 64'h1234, 3'b010, 3'b111, acc);
    in_valid_i = 1'b0;
    check("drain_cycles", 64'(n_drain), 64'd11);
    check("switch_cycles", 64'(n_switch), 64'd2);
    check("width_change_after_5", 64'(chg_pops - base), 64'd5);
    wait_idle();
    check("switch_results", 64'(n_pop - base), 64'd6);
    check("switch_width", {61'd0, dp_width_o}, 64'd7);

    // Illegal width job while running
    base = n_pop; accepts = n_err_out;
    send(64'h5, 64'h6, 3'b010, 3'b111, acc);
    send(64'hAAAA, 64'h5555, 3'b100, 3'b010, acc);
    in_valid_i = 1'b0;
    check("illegal_dp_x", dp_x_o, 64'd0);
    check("illegal_dp_y", dp_y_o, 64'd0);
    @(negedge clk); #1;
    check("illegal_stays_run", {62'd0, state_o}, 64'd1);
    check("illegal_mode_kept", {61'd0, dp_mode_o}, 64'd2);
    wait_idle();
    check("illegal_results", 64'(n_pop - base), 64'd2);
    check("illegal_err_seen", 64'(n_err_out - accepts), 64'd1);

    // Reset with 7 jobs in flight
    for (int i = 0; i < 7; i++)
      send(64'h900 + 64'(i), 64'h31 + 64'(i), 3'b001, 3'b011, acc);
    in_valid_i = 1'b0;
    #2 rst_n_i = 1'b0;
    #1;
    check("midrst_valid", {63'd0, out_valid_o}, 64'd0);
    check("midrst_busy", {63'd0, busy_o}, 64'd0);
    check("midrst_state", {62'd0, state_o}, 64'd0);
    check("midrst_dp_x", dp_x_o, 64'd0);
    check("midrst_width", {61'd0, dp_width_o}, 64'd0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n_i = 1'b1;
    base = n_pop;
    repeat (20) @(posedge clk);
    #1;
    check("no_stale_results", 64'(n_pop - base), 64'd0);
    send(64'h42, 64'h24, 3'b100, 3'b000, acc);
    wait_idle();
    check("post_rst_result", 64'(n_pop - base), 64'd1);

`ifdef SIMD_MULAND_CTRL_STATS_EN
    stat_clr_i = 1'b1;
    @(posedge clk); #1;
    stat_clr_i = 1'b0; n_drain = 0; n_switch = 0;
    for (int i = 0; i < 5; i++) send(64'h60 + 64'(i), 64'h9, 3'b001, 3'b000, acc);
    for (int i = 0; i < 5; i++) send(64'h70 + 64'(i), 64'hB, 3'b100, 3'b011, acc);
    wait_idle();
    check("stat_jobs", {32'd0, stat_jobs_o}, 64'd10);
    check("stat_drain", {32'd0, stat_drain_cyc_o}, 64'(n_drain + n_switch));
    check("stat_err", {48'd0, stat_err_o}, 64'd0);
    stat_clr_i = 1'b1;
    @(posedge clk); #1;
    stat_clr_i = 1'b0;
    check("stat_clr", {stat_jobs_o, stat_drain_cyc_o[15:0], stat_err_o}, 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
